// File: rtl/bbox_pkg.sv
// Shared types for the bbox ray/box stage and its RID wrapper; stream width macros live here too.
// Latency: none (types only). Backpressure: n/a.
`ifndef BBOX_DATATYPES_SVH
`define BBOX_DATATYPES_SVH
`define RID_WIDTH 4
`define BBOX_REQ_WIDTH (640 + `RID_WIDTH)
`define BBOX_RESP_WIDTH (3 + `RID_WIDTH)
`endif

package bbox_pkg;
  localparam int BBOX_PAYLOAD_WIDTH = 640;
  localparam int BBOX_HIT_WIDTH     = 3;
  localparam int RID_W              = `RID_WIDTH;

  typedef struct packed {
    logic [BBOX_PAYLOAD_WIDTH-1:0] payload;
    logic [RID_W-1:0]              rid;
  } bbox_req_t;

  typedef struct packed {
    logic [BBOX_HIT_WIDTH-1:0] hit;
    logic [RID_W-1:0]          rid;
  } bbox_resp_t;
endpackage

// File: rtl/rid_freelist.sv
// RID pool: free bitmap, lowest-free allocation, free port, allocation query, outstanding count.
// Latency: alloc/free take effect on the next edge. Backpressure: o_any_free low when pool is empty.
module rid_freelist #(
  parameter int N  = 16,
  parameter int RW = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_alloc,
  output logic [RW-1:0] o_alloc_rid,
  output logic          o_any_free,
  input  logic          i_free,
  input  logic [RW-1:0] i_free_rid,
  input  logic [RW-1:0] i_query_rid,
  output logic          o_is_alloc,
  output logic [CW-1:0] o_outstanding
);
  logic [N-1:0]       r_free;
  logic [CW-1:0]      r_outstanding;
  logic [2**RW-1:0]   w_alloc_map;
  logic               w_alloc;
  logic               w_free;

  // Padding the allocated map to the full RID space makes out-of-range RIDs read as unallocated.
  assign w_alloc_map   = (2**RW)'(~r_free);
  assign o_any_free    = |r_free;
  assign w_alloc       = i_alloc && o_any_free;
  assign w_free        = i_free && w_alloc_map[i_free_rid];
  assign o_is_alloc    = w_alloc_map[i_query_rid];
  assign o_outstanding = r_outstanding;

  always_comb begin
    o_alloc_rid = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_free[i]) o_alloc_rid = RW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free        <= '1;
      r_outstanding <= '0;
    end else begin
      if (w_alloc) r_free[o_alloc_rid] <= 1'b0;
      if (w_free)  r_free[i_free_rid]  <= 1'b1;
      case ({w_alloc, w_free})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end
endmodule

// File: rtl/bbox_rid_ctrl.sv
// Tags requests with a free RID for bbox and restores caller context on return; 1-cycle latency each way.
// Each path has one skid-free output register; BBOX_RID_CHECK_EN drops and flags responses for unallocated RIDs.
module bbox_rid_ctrl
  import bbox_pkg::*;
#(
  parameter int CTX_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 16,
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BBOX_PAYLOAD_WIDTH-1:0] in_req_dat,
  input  logic [CTX_WIDTH-1:0]          in_req_ctx,
  input  logic                          in_req_vld,
  output logic                          in_req_rdy,
  output logic [`BBOX_REQ_WIDTH-1:0]    bbox_req_stream_rsc_dat,
  output logic                          bbox_req_stream_rsc_vld,
  input  logic                          bbox_req_stream_rsc_rdy,
  input  logic [`BBOX_RESP_WIDTH-1:0]   bbox_resp_stream_rsc_dat,
  input  logic                          bbox_resp_stream_rsc_vld,
  output logic                          bbox_resp_stream_rsc_rdy,
  output logic [BBOX_HIT_WIDTH-1:0]     out_resp_hit,
  output logic [CTX_WIDTH-1:0]          out_resp_ctx,
  output logic                          out_resp_vld,
  input  logic                          out_resp_rdy,
  output logic [OUT_W-1:0]              outstanding,
  output logic                          err_rid
);
  bbox_req_t                 r_req;
  logic                      r_req_vld;
  logic [BBOX_HIT_WIDTH-1:0] r_hit;
  logic [CTX_WIDTH-1:0]      r_ctx;
  logic                      r_resp_vld;
  logic [CTX_WIDTH-1:0]      r_ctx_mem [MAX_OUTSTANDING];

  bbox_resp_t                w_resp;
  logic [RID_W-1:0]          w_alloc_rid;
  logic                      w_any_free;
  logic                      w_is_alloc;
  logic                      w_req_acc;
  logic                      w_resp_acc;
  logic                      w_resp_ok;
  logic                      w_fwd;

  assign w_resp                   = bbox_resp_t'(bbox_resp_stream_rsc_dat);
  assign in_req_rdy               = !rst && w_any_free && (!r_req_vld || bbox_req_stream_rsc_rdy);
  assign bbox_resp_stream_rsc_rdy = !rst && (!r_resp_vld || out_resp_rdy);
  assign w_req_acc                = in_req_vld && in_req_rdy;
  assign w_resp_acc               = bbox_resp_stream_rsc_vld && bbox_resp_stream_rsc_rdy;
  assign w_fwd                    = w_resp_acc && w_resp_ok;

`ifdef BBOX_RID_CHECK_EN
  logic r_err;
  assign w_resp_ok = w_is_alloc;
  assign err_rid   = r_err;
  always_ff @(posedge clk) begin
    if (rst)                            r_err <= 1'b0;
    else if (w_resp_acc && !w_is_alloc) r_err <= 1'b1;
  end
`else
  logic w_unused_is_alloc;
  assign w_unused_is_alloc = w_is_alloc;
  assign w_resp_ok         = 1'b1;
  assign err_rid           = 1'b0;
`endif

  rid_freelist #(
    .N  (MAX_OUTSTANDING),
    .RW (RID_W)
  ) u_freelist (
    .clk           (clk),
    .rst           (rst),
    .i_alloc       (w_req_acc),
    .o_alloc_rid   (w_alloc_rid),
    .o_any_free    (w_any_free),
    .i_free        (w_fwd),
    .i_free_rid    (w_resp.rid),
    .i_query_rid   (w_resp.rid),
    .o_is_alloc    (w_is_alloc),
    .o_outstanding (outstanding)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_vld <= 1'b0;
      r_req     <= '0;
    end else if (w_req_acc) begin
      r_req_vld     <= 1'b1;
      r_req.payload <= in_req_dat;
      r_req.rid     <= w_alloc_rid;
    end else if (bbox_req_stream_rsc_rdy) begin
      r_req_vld <= 1'b0;
    end
  end

  // Context storage is left unreset; a slot is only read after its RID was written on allocation.
  always_ff @(posedge clk) begin
    if (w_req_acc) r_ctx_mem[w_alloc_rid] <= in_req_ctx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_vld <= 1'b0;
      r_hit      <= '0;
      r_ctx      <= '0;
    end else if (w_fwd) begin
      r_resp_vld <= 1'b1;
      r_hit      <= w_resp.hit;
      r_ctx      <= r_ctx_mem[w_resp.rid];
    end else if (out_resp_rdy) begin
      r_resp_vld <= 1'b0;
    end
  end

  assign bbox_req_stream_rsc_dat = r_req;
  assign bbox_req_stream_rsc_vld = r_req_vld;
  assign out_resp_hit            = r_hit;
  assign out_resp_ctx            = r_ctx;
  assign out_resp_vld            = r_resp_vld;
endmodule

// File: doc/bbox_rid_ctrl.md
# bbox_rid_ctrl

Request-ID controller placed directly upstream of the `bbox` ray/box intersection stage. It accepts untagged box-test requests with a caller context and assigns each a free RID. It forwards the tagged request to `bbox`, consumes `bbox` responses, recovers the caller context by RID, frees the RID, and returns hit bits plus context to the traversal logic. This lets `bbox` run fully pipelined with up to `MAX_OUTSTANDING` requests in flight.

## Interface
Parameters:
- `CTX_WIDTH`, 32: opaque caller context carried alongside each request.
- `MAX_OUTSTANDING`, 16: RID pool size; must be ≤ 2**`RID_WIDTH`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_req_dat`  in  640  box-test payload (ray + box), untagged.
- `in_req_ctx`  in  `CTX_WIDTH`  caller context.
- `in_req_vld` / `in_req_rdy`  in / out  1  request handshake.
- `bbox_req_stream_rsc_dat`  out  `BBOX_REQ_WIDTH`  {payload, RID}, with RID in the low `RID_WIDTH` bits.
- `bbox_req_stream_rsc_vld` / `bbox_req_stream_rsc_rdy`  out / in  1  handshake to `bbox`.
- `bbox_resp_stream_rsc_dat`  in  `BBOX_RESP_WIDTH`  {hit[2:0], RID}.
- `bbox_resp_stream_rsc_vld` / `bbox_resp_stream_rsc_rdy`  in / out  1  handshake from `bbox`.
- `out_resp_hit`  out  3  hit bits copied from the response.
- `out_resp_ctx`  out  `CTX_WIDTH`  context recovered by RID.
- `out_resp_vld` / `out_resp_rdy`  out / in  1  result handshake.
- `outstanding`  out  clog2(`MAX_OUTSTANDING`+1)  number of allocated RIDs.
- `err_rid`  out  1  sticky flag: a response arrived with an unallocated RID.

## Operation
- All handshakes: a transfer occurs on a rising edge with vld&&rdy. Once vld is asserted, dat stays stable until the transfer.
- RID pool: bitmap of `MAX_OUTSTANDING` bits, set = free. Allocation always takes the lowest-index free RID, computed from the registered bitmap.
- Request path, one output register:
  - `in_req_rdy` = at least one free RID && (output register empty || `bbox_req_stream_rsc_rdy`).
  - On accept: clear the allocated RID's bit, write `ctx_mem[RID]` = `in_req_ctx`, load the register with {`in_req_dat`, RID}, set vld.
- Response path, one output register:
  - `bbox_resp_stream_rsc_rdy` = register empty || `out_resp_rdy`.
  - On accept: read `ctx_mem[RID]`, set the RID's bit free, load `out_resp_hit`/`out_resp_ctx`, set vld.
- Simultaneous allocation and free in the same cycle: both bitmap updates apply. A RID freed in cycle N is allocatable no earlier than cycle N+1.
- `outstanding` = `MAX_OUTSTANDING` − popcount(bitmap). It is updated registered and stays consistent when allocation and free coincide.
- Pool full: `in_req_rdy`=0. The response path continues, so the pool cannot deadlock.
- Returned RID ≥ `MAX_OUTSTANDING`: treated as unallocated.
- Reset, including mid-operation: all in-flight state is discarded, the bitmap becomes all-free, and `ctx_mem` contents are don't-care.

## Timing
- Reset values: `in_req_rdy`=0 during reset, then 1 on the first cycle after; `bbox_req_stream_rsc_vld`=0; `bbox_resp_stream_rsc_rdy`=0 during reset; `out_resp_vld`=0; `outstanding`=0; `err_rid`=0; data outputs 0.
- Request latency: 1 cycle from `in_req` accept to `bbox_req_stream_rsc_vld`.
- Response latency: 1 cycle from `bbox_resp` accept to `out_resp_vld`.
- Throughput: 1 request/cycle and 1 response/cycle concurrently when not backpressured.
- Backpressure: no combinational path from `out_resp_rdy` to `in_req_rdy`.
- `ctx_mem`: written and read in the same cycle for the same RID is not possible, because a RID cannot be allocated and returned in the same cycle.

## Configuration
- `BBOX_RID_CHECK_EN` defined:
  - Each response RID is checked against the bitmap.
  - An unallocated RID sets `err_rid` (sticky until reset), and the response is consumed and discarded with no `out_resp` beat and no bitmap change.
- Not defined:
  - No check. `err_rid` is tied to 0.
  - Every response is forwarded and its bit set free unconditionally.

## Structure
- Shared package `bbox_pkg`:
  - `BBOX_PAYLOAD_WIDTH`=640, `BBOX_HIT_WIDTH`=3.
  - Packed structs `bbox_req_t` {payload, rid} and `bbox_resp_t` {hit, rid}.
  - Width macros `RID_WIDTH`, `BBOX_REQ_WIDTH`, `BBOX_RESP_WIDTH` stay in the existing datatypes header.
- Sub-module `rid_freelist`:
  - Contents: bitmap, lowest-free priority encoder, alloc/free ports, `any_free`, `outstanding` counter, `is_alloc(rid)` query.
- `ctx_mem`: flop array inside the top level.

## Test plan
All scenarios use defaults (`MAX_OUTSTANDING`=16, `RID_WIDTH`=4).
1. Single request with ctx=0xDEADBEEF, `bbox` returns hit=3'b101 for RID 0 → `bbox_req` RID=0 one cycle after accept; `out_resp_hit`=101, `out_resp_ctx`=0xDEADBEEF; `outstanding` goes 0→1→0.
2. 16 back-to-back requests with `bbox` responses held off → RIDs 0..15 issued in order; `outstanding`=16; `in_req_rdy`=0 on the 17th. Return RID 7 → next request gets RID 7 no earlier than the following cycle.
3. Out-of-order returns with RIDs 3,0,2,1 carrying ctx 30,0,20,10 → `out_resp_ctx` is 30,0,20,10 respectively.
4. `out_resp_rdy`=0 for 5 cycles with one result pending → `bbox_resp_stream_rsc_rdy`=0 and `out_resp` data stable; all beats drain after release with no loss.
5. With `BBOX_RID_CHECK_EN`, response with RID 9 while idle → `err_rid`=1, no `out_resp_vld`, `outstanding` stays 0. Without the macro → beat is forwarded and `err_rid`=0.
6. `rst` pulsed with 5 RIDs outstanding → next cycle `outstanding`=0, all vld=0, and the next request gets RID 0.
